// File: rtl/memory_stage.sv
// memory_stage: MEM stage with a single-outstanding load/store bus access and a registered writeback packet.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module memory_stage #(
    parameter int XLEN        = 32,
    parameter int CW_EX_WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [CW_EX_WIDTH-1:0] control_word_ex,
    input  logic [XLEN-1:0]        calculated_adr,
    input  logic [XLEN-1:0]        ALU_result,
    input  logic [XLEN-1:0]        pc_plus_4_ex,
    input  logic [XLEN-1:0]        regfileb_ex,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [XLEN-1:0]        dmem_addr,
    output logic [3:0]             dmem_be,
    output logic [XLEN-1:0]        dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [XLEN-1:0]        dmem_rdata,
    output logic                   wb_valid,
    output logic                   wb_rf_wb,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic                   misalign_exc,
    output logic [XLEN-1:0]        misalign_adr
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            r_state;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [XLEN-1:0]   r_dmem_addr;
    logic [3:0]        r_dmem_be;
    logic [XLEN-1:0]   r_dmem_wdata;
    logic              r_wb_valid;
    logic              r_wb_rf_wb;
    logic [4:0]        r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic [2:0]        r_funct3;
    logic [1:0]        r_adr_lo;
    logic [1:0]        r_wb_src;
    logic              r_rf_wb;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_pc4;
    logic              w_rf_wb;
    logic              w_mem_we;
    logic [1:0]        w_wb_src;
    logic [4:0]        w_rd;
    logic [2:0]        w_funct3;
    logic              w_is_load;
    logic              w_is_mem;
    logic              w_accept;
    logic              w_misalign;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_nonmem_data;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic              w_ld_signed;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_unused;
    // Branch/redirect bits are consumed in EX and only travel through here.
    assign w_unused      = ^{control_word_ex[13], control_word_ex[8]};
    assign w_rf_wb       = control_word_ex[12];
    assign w_mem_we      = control_word_ex[11];
    assign w_wb_src      = control_word_ex[10:9];
    assign w_rd          = control_word_ex[7:3];
    assign w_funct3      = control_word_ex[2:0];
    assign w_is_load     = (w_wb_src == 2'b01) & ~w_mem_we;
    assign w_is_mem      = w_mem_we | w_is_load;
    assign ex_ready      = (r_state == IDLE);
    assign w_accept      = ex_valid & ex_ready;
    assign w_be          = ~w_mem_we ? 4'b1111 :
                           (w_funct3 == 3'b000) ? 4'b0001 << calculated_adr[1:0] :
                           (w_funct3 == 3'b001) ? (calculated_adr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata       = (w_funct3 == 3'b000) ? {4{regfileb_ex[7:0]}} :
                           (w_funct3 == 3'b001) ? {2{regfileb_ex[15:0]}} : regfileb_ex;
    assign w_nonmem_data = (w_wb_src == 2'b10) ? pc_plus_4_ex : ALU_result;
    assign w_ld_byte     = (r_adr_lo == 2'd0) ? dmem_rdata[7:0] :
                           (r_adr_lo == 2'd1) ? dmem_rdata[15:8] :
                           (r_adr_lo == 2'd2) ? dmem_rdata[23:16] : dmem_rdata[31:24];
    assign w_ld_half     = r_adr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign w_ld_signed   = ~r_funct3[2];
    assign w_ld_data     = (r_funct3[1:0] == 2'b00) ? {{24{w_ld_signed & w_ld_byte[7]}}, w_ld_byte} :
                           (r_funct3[1:0] == 2'b01) ? {{16{w_ld_signed & w_ld_half[15]}}, w_ld_half} : dmem_rdata;
`ifdef MISALIGN_TRAP_EN
    logic            w_half;
    logic            w_word;
    logic            r_misalign_exc;
    logic [XLEN-1:0] r_misalign_adr;
    // Stores and loads size their funct3 differently: SW covers every code above SH.
    assign w_half     = w_mem_we ? (w_funct3 == 3'b001) : (w_funct3[1:0] == 2'b01);
    assign w_word     = w_mem_we ? (w_funct3[2:1] != 2'b00) : w_funct3[1];
    assign w_misalign = w_is_mem & ((w_half & calculated_adr[0]) | (w_word & |calculated_adr[1:0]));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_exc <= 1'b0;
            r_misalign_adr <= '0;
        end else begin
            r_misalign_exc <= w_accept & w_misalign;
            if (w_accept & w_misalign)
                r_misalign_adr <= calculated_adr;
        end
    end
    assign misalign_exc = r_misalign_exc;
    assign misalign_adr = r_misalign_adr;
`else
    assign w_misalign   = 1'b0;
    assign misalign_exc = 1'b0;
    assign misalign_adr = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rf_wb   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_funct3     <= '0;
            r_adr_lo     <= '0;
            r_wb_src     <= '0;
            r_rf_wb      <= 1'b0;
            r_rd         <= '0;
            r_alu        <= '0;
            r_pc4        <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (ex_valid) begin
                    r_funct3 <= w_funct3;
                    r_adr_lo <= calculated_adr[1:0];
                    r_wb_src <= w_wb_src;
                    r_rf_wb  <= w_rf_wb & ~w_mem_we;
                    r_rd     <= w_rd;
                    r_alu    <= ALU_result;
                    r_pc4    <= pc_plus_4_ex;
                    if (w_is_mem & ~w_misalign) begin
                        r_state      <= ACCESS;
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_mem_we;
                        r_dmem_addr  <= {calculated_adr[XLEN-1:2], 2'b00};
                        r_dmem_be    <= w_be;
                        r_dmem_wdata <= w_wdata;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_wb_rf_wb <= w_rf_wb & ~w_mem_we & ~w_misalign;
                        r_wb_rd    <= w_rd;
                        r_wb_data  <= w_nonmem_data;
                    end
                end
            end else if (dmem_ack) begin
                r_state    <= IDLE;
                r_dmem_req <= 1'b0;
                r_wb_valid <= 1'b1;
                r_wb_rf_wb <= r_rf_wb;
                r_wb_rd    <= r_rd;
                r_wb_data  <= (r_wb_src == 2'b01) ? w_ld_data : (r_wb_src == 2'b10) ? r_pc4 : r_alu;
            end
        end
    end
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_be    = r_dmem_be;
    assign dmem_wdata = r_dmem_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_rf_wb   = r_wb_rf_wb;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
endmodule
